// File: rtl/shifter_pkg.sv
// Shared types for the multi-cycle shift unit: FSM state encoding and the
// nibble step size used when SEQUENTIAL_SHIFTER_NIBBLE_STEP_EN is defined.
package shifter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam int NIBBLE_STEP = 4;

endpackage

// File: rtl/shift_step.sv
// Combinational single step of the sequential shifter: moves the operand by
// one or NIBBLE_STEP positions, left with zero fill or right with zero/sign fill.
import shifter_pkg::*;

module shift_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] data,
  input  logic            left,
  input  logic            arith,
  input  logic            nibble,
  output logic [XLEN-1:0] result
);

  logic fill;

  always_comb begin
    fill = arith & data[XLEN-1];
    result = data;
    if (left) begin
      result = nibble ? {data[XLEN-NIBBLE_STEP-1:0], {NIBBLE_STEP{1'b0}}}
                      : {data[XLEN-2:0], 1'b0};
    end else begin
      result = nibble ? {{NIBBLE_STEP{fill}}, data[XLEN-1:NIBBLE_STEP]}
                      : {fill, data[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/sequential_shifter.sv
// Multi-cycle logical/arithmetic shifter with valid/ready on both sides.
// Define SEQUENTIAL_SHIFTER_NIBBLE_STEP_EN to step 4 positions while >= 4 remain.
import shifter_pkg::*;

module sequential_shifter #(
  parameter int XLEN = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    valid_in,
  output logic                    ready_out,
  input  logic [XLEN-1:0]         in_data,
  input  logic [$clog2(XLEN)-1:0] shamt,
  input  logic                    left_or_right_shift,
  input  logic                    arithmetic_right_shift,
  output logic                    valid_out,
  input  logic                    ready_in,
  output logic [XLEN-1:0]         out_data
);

  localparam int SHW = $clog2(XLEN);

  state_t          state;
  logic [XLEN-1:0] data_reg;
  logic [SHW-1:0]  remaining;
  logic            left_mode;
  logic            arith_mode;
  logic            use_nibble;
  logic [SHW-1:0]  step_amt;
  logic [XLEN-1:0] step_result;

`ifdef SEQUENTIAL_SHIFTER_NIBBLE_STEP_EN
  assign use_nibble = (remaining >= SHW'(NIBBLE_STEP));
`else
  assign use_nibble = 1'b0;
`endif

  assign step_amt = use_nibble ? SHW'(NIBBLE_STEP) : SHW'(1);

  shift_step #(
    .XLEN(XLEN)
  ) u_step (
    .data  (data_reg),
    .left  (left_mode),
    .arith (arith_mode),
    .nibble(use_nibble),
    .result(step_result)
  );

  // Handshake outputs are registered alongside the state so that neither
  // valid_in nor ready_in can reach an output combinationally.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      ready_out  <= 1'b1;
      valid_out  <= 1'b0;
      data_reg   <= '0;
      remaining  <= '0;
      left_mode  <= 1'b0;
      arith_mode <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_in) begin
            data_reg   <= in_data;
            remaining  <= shamt;
            left_mode  <= left_or_right_shift;
            arith_mode <= arithmetic_right_shift;
            ready_out  <= 1'b0;
            if (shamt == '0) begin
              state     <= DONE;
              valid_out <= 1'b1;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          data_reg  <= step_result;
          remaining <= remaining - step_amt;
          if (remaining == step_amt) begin
            state     <= DONE;
            valid_out <= 1'b1;
          end
        end
        DONE: begin
          if (ready_in) begin
            state     <= IDLE;
            valid_out <= 1'b0;
            ready_out <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          valid_out <= 1'b0;
          ready_out <= 1'b1;
        end
      endcase
    end
  end

  assign out_data = data_reg;

endmodule

// File: tb/tb_sequential_shifter.sv
// Scoreboard bench for sequential_shifter; expected results come from a
// full barrel-shift model and latency from the step rule of the active build.
module tb_sequential_shifter;

  localparam int XLEN = 32;
  localparam int SHW  = 5;

  logic            clock = 1'b0;
  logic            reset;
  logic            valid_in;
  logic            ready_out;
  logic [XLEN-1:0] in_data;
  logic [SHW-1:0]  shamt;
  logic            left_or_right_shift;
  logic            arithmetic_right_shift;
  logic            valid_out;
  logic            ready_in;
  logic [XLEN-1:0] out_data;

  int vectors = 0;
  int miscompares = 0;

  logic [XLEN-1:0] exp_q[$];
  int              lat_q[$];

  always #5 clock = ~clock;

  sequential_shifter #(.XLEN(XLEN)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .valid_in              (valid_in),
    .ready_out             (ready_out),
    .in_data               (in_data),
    .shamt                 (shamt),
    .left_or_right_shift   (left_or_right_shift),
    .arithmetic_right_shift(arithmetic_right_shift),
    .valid_out             (valid_out),
    .ready_in              (ready_in),
    .out_data              (out_data)
  );

  function automatic logic [XLEN-1:0] barrel(input logic [XLEN-1:0] d, input int s,
                                             input logic l, input logic a);
    logic signed [XLEN-1:0] sd;
    sd = d;
    if (l) return d << s;
    if (a) return XLEN'(sd >>> s);
    return d >> s;
  endfunction

  function automatic int exp_latency(input int s);
`ifdef SEQUENTIAL_SHIFTER_NIBBLE_STEP_EN
    return s / 4 + s % 4 + 1;
`else
    return s + 1;
`endif
  endfunction

  // Waits (bounded) for IDLE, presents one request for the accept edge, then
  // scrambles the inputs so late changes would corrupt a non-capturing design.
  task automatic send(input logic [XLEN-1:0] d, input int s, input logic l, input logic a);
    int n;
    n = 0;
    while (!ready_out && n < 200) begin
      @(posedge clock); #1; n++;
    end
    vectors++;
    if (ready_out !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL send_ready: ready_out=%b required 1", ready_out);
    end
    valid_in = 1'b1;
    in_data = d;
    shamt = SHW'(s);
    left_or_right_shift = l;
    arithmetic_right_shift = a;
    @(posedge clock); #1;
    valid_in = 1'b0;
    in_data = $urandom;
    shamt = SHW'($urandom);
    left_or_right_shift = 1'($urandom);
    arithmetic_right_shift = 1'($urandom);
    exp_q.push_back(barrel(d, s, l, a));
    lat_q.push_back(exp_latency(s));
  endtask

  task automatic wait_result(output logic [XLEN-1:0] act, output int lat);
    lat = 1;
    while (!valid_out && lat < 200) begin
      @(posedge clock); #1; lat++;
    end
    act = out_data;
  endtask

  task automatic consume();
    ready_in = 1'b1;
    @(posedge clock); #1;
    ready_in = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    valid_in = 1'b0;
    ready_in = 1'b0;
    in_data = '0;
    shamt = '0;
    left_or_right_shift = 1'b0;
    arithmetic_right_shift = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    vectors++;
    if (ready_out !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_ready: got %b required 1", ready_out);
    end
    vectors++;
    if (valid_out !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_valid: got %b required 0", valid_out);
    end
    vectors++;
    if (out_data !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_data: got %h required 0", out_data);
    end
  endtask

  task automatic test_directed();
    logic [XLEN-1:0] tbl_d[8] = '{32'h0000_0001, 32'h8000_00F0, 32'h8000_00F0, 32'h8000_00F0,
                                  32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h8765_4321};
    int   tbl_s[8] = '{31, 4, 4, 4, 0, 0, 0, 9};
    logic tbl_l[8] = '{1, 0, 0, 1, 1, 0, 0, 0};
    logic tbl_a[8] = '{0, 0, 1, 1, 0, 0, 1, 1};
    logic [XLEN-1:0] act, exp;
    int lat, el;
    for (int i = 0; i < 8; i++) begin
      send(tbl_d[i], tbl_s[i], tbl_l[i], tbl_a[i]);
      wait_result(act, lat);
      exp = exp_q.pop_front();
      el = lat_q.pop_front();
      vectors++;
      if (act !== exp) begin
        miscompares++;
        $display("[TB] FAIL directed_data[%0d]: got %h required %h", i, act, exp);
      end
      vectors++;
      if (lat !== el) begin
        miscompares++;
        $display("[TB] FAIL directed_latency[%0d]: got %0d required %0d", i, lat, el);
      end
      consume();
    end
  endtask

  task automatic test_backpressure();
    logic [XLEN-1:0] act, exp;
    int lat, el;
    send(32'h8000_00F0, 4, 1'b0, 1'b1);
    wait_result(act, lat);
    exp = exp_q.pop_front();
    el = lat_q.pop_front();
    vectors++;
    if (act !== exp || lat !== el) begin
      miscompares++;
      $display("[TB] FAIL bp_result: got %h/%0d required %h/%0d", act, lat, exp, el);
    end
    for (int i = 0; i < 10; i++) begin
      valid_in = 1'b1;
      in_data = $urandom;
      shamt = SHW'($urandom);
      @(posedge clock); #1;
      vectors++;
      if (out_data !== exp || valid_out !== 1'b1 || ready_out !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL bp_hold[%0d]: got data=%h v=%b r=%b required %h 1 0",
                 i, out_data, valid_out, ready_out, exp);
      end
    end
    valid_in = 1'b0;
    consume();
    vectors++;
    if (ready_out !== 1'b1 || valid_out !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL bp_release: got r=%b v=%b required 1 0", ready_out, valid_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [XLEN-1:0] act, exp;
    int lat, el;
    send(32'h1234_5678, 3, 1'b0, 1'b0);
    wait_result(act, lat);
    exp = exp_q.pop_front();
    el = lat_q.pop_front();
    vectors++;
    if (act !== exp || lat !== el) begin
      miscompares++;
      $display("[TB] FAIL b2b_first: got %h/%0d required %h/%0d", act, lat, exp, el);
    end
    valid_in = 1'b1;
    in_data = 32'hF000_0000;
    shamt = SHW'(2);
    left_or_right_shift = 1'b0;
    arithmetic_right_shift = 1'b1;
    ready_in = 1'b1;
    @(posedge clock); #1;
    ready_in = 1'b0;
    vectors++;
    if (ready_out !== 1'b1 || valid_out !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL b2b_idle: got r=%b v=%b required 1 0", ready_out, valid_out);
    end
    @(posedge clock); #1;
    valid_in = 1'b0;
    exp_q.push_back(barrel(32'hF000_0000, 2, 1'b0, 1'b1));
    lat_q.push_back(exp_latency(2));
    vectors++;
    if (ready_out !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL b2b_accept: ready_out=%b required 0", ready_out);
    end
    wait_result(act, lat);
    exp = exp_q.pop_front();
    el = lat_q.pop_front();
    vectors++;
    if (act !== exp || lat !== el) begin
      miscompares++;
      $display("[TB] FAIL b2b_second: got %h/%0d required %h/%0d", act, lat, exp, el);
    end
    consume();
  endtask

  task automatic test_mid_reset();
    send(32'hCAFE_F00D, 20, 1'b1, 1'b0);
    repeat (5) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    exp_q.delete();
    lat_q.delete();
    vectors++;
    if (ready_out !== 1'b1 || valid_out !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midreset_state: got r=%b v=%b required 1 0", ready_out, valid_out);
    end
    vectors++;
    if (out_data !== '0) begin
      miscompares++;
      $display("[TB] FAIL midreset_data: got %h required 0", out_data);
    end
  endtask

  task automatic test_random();
    logic [XLEN-1:0] act, exp, d;
    int lat, el, s;
    logic l, a;
    for (int i = 0; i < 96; i++) begin
      d = $urandom;
      s = $urandom_range(0, XLEN - 1);
      l = 1'($urandom);
      a = 1'($urandom);
      send(d, s, l, a);
      wait_result(act, lat);
      exp = exp_q.pop_front();
      el = lat_q.pop_front();
      vectors++;
      if (act !== exp) begin
        miscompares++;
        $display("[TB] FAIL random_data[%0d]: in=%h s=%0d l=%b a=%b got %h required %h",
                 i, d, s, l, a, act, exp);
      end
      vectors++;
      if (lat !== el) begin
        miscompares++;
        $display("[TB] FAIL random_latency[%0d]: s=%0d got %0d required %0d", i, s, lat, el);
      end
      consume();
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
